riscv_fetch: RTL
================

Name: riscv_fetch

Overview:
Instruction fetch stage that sits directly upstream of the control decoder. It holds the PC and issues word reads to instruction memory over a valid/ready request channel. It buffers returned instructions in a 2-entry queue and presents them, with their PC and pre-sliced opcode/funct3/funct7 fields, to decode over a valid/ready channel. Taken-branch redirects (pc_src plus target) flush the queue and squash any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; must be word aligned
QDEPTH, 2, instruction queue depth; fixed at 2, and the RTL only has to support 2

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  read data valid; no back-pressure, arrives at least 1 cycle after request accept
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  taken branch (pc_src from control)
redirect_target  in  32  branch target address
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode consumes instruction
inst_out  out  32  instruction word (queue head)
inst_pc  out  32  PC of inst_out
opcode  out  7  inst_out[6:0]
funct3  out  3  inst_out[14:12]
funct7  out  7  inst_out[31:25]

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc = RESET_PC; queue empty; outstanding = 0; drop = 0.
  - Outputs: imem_req_valid=0, inst_valid=0, inst_out=0, inst_pc=0.
- First cycle with rst=0: imem_req_valid=1, imem_req_addr=RESET_PC.
- Request FSM states:
  - REQ: imem_req_valid=1 iff (queue_count + outstanding) < QDEPTH.
    - On handshake (valid&ready): outstanding=1, fetch_pc += 4 (wraps mod 2^32), go to WAIT.
  - WAIT: imem_req_valid=0 (at most one outstanding request).
    - On imem_rsp_valid: outstanding=0, go to REQ.
    - If drop=0: push {pc_of_request, imem_rsp_data} into the queue.
    - If drop=1: discard the response and clear drop.
- Request stability: imem_req_addr and imem_req_valid are held stable until the handshake, except when a redirect occurs.
- Queue: 2-entry FIFO of {pc, instr}.
  - inst_valid = !empty.
  - Pop on inst_valid&inst_ready.
  - Push and pop in the same cycle is allowed; count is unchanged.
  - The credit check above guarantees a push never finds the queue full.
- Decode outputs: opcode/funct3/funct7 are combinational slices of inst_out. All fields read 0 when the queue is empty.
- Redirect (redirect_valid=1) has highest priority:
  - Queue flushed, including any pop in the same cycle; the popped instruction is still considered consumed by decode.
  - fetch_pc = {redirect_target[31:2], 2'b00}.
  - A request accepted in the same cycle, or already outstanding with no response this cycle, sets drop=1.
  - A response arriving in the same cycle is discarded, and drop is not set for it.
  - FSM goes to REQ if no request remains outstanding, otherwise WAIT.
  - Next cycle: imem_req_valid=1 with the new address (when nothing is outstanding).
- Back-to-back redirects: the last one wins. drop stays 1 until the single outstanding response is consumed.
- Reset mid-operation: all state is cleared immediately. A memory response arriving after reset while outstanding=0 is ignored.
- Latency: redirect at cycle N gives req at N+1. With zero-wait memory (accept at N+1, rsp at N+2), inst_valid=1 at N+3.

Test Plan:
- Reset then sequential fetch: RESET_PC=0, ready=1, rsp 1 cycle after accept with data=addr^32'hA5A5A5A5, inst_ready=1 -> inst_pc sequence 0,4,8,C; inst_out matches; opcode = data[6:0].
- Back-pressure: inst_ready=0 -> exactly 2 requests issued (0,4), then imem_req_valid=0. Raise inst_ready -> 0 popped first, then the request for 8 is issued.
- Redirect while WAIT: redirect to 32'h103 while the request for 8 is outstanding -> rsp for 8 dropped, queue empty, next req addr=32'h100, inst_pc=32'h100.
- Redirect simultaneous with req handshake and with rsp_valid in separate cases -> neither stale instruction ever reaches inst_valid. Next req addr=target.
- Memory stall: imem_req_ready=0 for 5 cycles -> imem_req_addr held constant, imem_req_valid held 1, no PC advance.
- Mid-run reset: assert rst while outstanding=1, then deliver the late rsp -> inst_valid stays 0; first post-reset req addr=RESET_PC.

Source files
------------

// File: rtl/riscv_fetch.sv
// riscv_fetch: holds the PC, issues one word fetch at a time and buffers
// returned instructions in a 2-entry queue that feeds the decoder.
// Taken-branch redirects flush the queue and squash any in-flight fetch.
module riscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);

  localparam logic [1:0] QDEPTH_L = 2'(QDEPTH);

  typedef enum logic [0:0] {
    ST_REQ  = 1'b0,
    ST_WAIT = 1'b1
  } req_state_t;

  req_state_t  state_r, state_s;
  logic [31:0] fetch_pc_r, fetch_pc_s;
  logic [31:0] req_pc_r, req_pc_s;
  logic        drop_r, drop_s;

  logic [31:0] q_pc_r   [2];
  logic [31:0] q_inst_r [2];
  logic [1:0]  q_count_r, q_count_s;
  logic        q_rd_ptr_r, q_rd_ptr_s;
  logic        q_wr_ptr_r, q_wr_ptr_s;

  logic        req_fire_s;
  logic        rsp_fire_s;
  logic        push_s;
  logic        pop_s;
  logic        unused_tgt_s;

  // The low target bits are discarded when aligning the redirect address.
  assign unused_tgt_s = ^redirect_target[1:0];

  // Handshakes and queue-facing outputs derived from the registered state.
  always_comb begin
    imem_req_valid = (!rst) && (state_r == ST_REQ) && (q_count_r < QDEPTH_L);
    imem_req_addr  = fetch_pc_r;
    req_fire_s     = imem_req_valid && imem_req_ready;
    rsp_fire_s     = (state_r == ST_WAIT) && imem_rsp_valid;
    inst_valid     = (q_count_r != 2'd0);
    pop_s          = inst_valid && inst_ready;
    push_s         = rsp_fire_s && !drop_r && !redirect_valid;
    if (inst_valid) begin
      inst_out = q_inst_r[q_rd_ptr_r];
      inst_pc  = q_pc_r[q_rd_ptr_r];
    end else begin
      inst_out = 32'd0;
      inst_pc  = 32'd0;
    end
    opcode = inst_out[6:0];
    funct3 = inst_out[14:12];
    funct7 = inst_out[31:25];
  end

  // Request FSM next state: redirect overrides, a squashed fetch sets drop.
  always_comb begin
    state_s    = state_r;
    fetch_pc_s = fetch_pc_r;
    req_pc_s   = req_pc_r;
    drop_s     = drop_r;
    if (redirect_valid) begin
      fetch_pc_s = {redirect_target[31:2], 2'b00};
      if (req_fire_s) begin
        state_s  = ST_WAIT;
        req_pc_s = fetch_pc_r;
        drop_s   = 1'b1;
      end else if ((state_r == ST_WAIT) && !imem_rsp_valid) begin
        state_s = ST_WAIT;
        drop_s  = 1'b1;
      end else begin
        state_s = ST_REQ;
        drop_s  = 1'b0;
      end
    end else begin
      case (state_r)
        ST_REQ: begin
          if (req_fire_s) begin
            state_s    = ST_WAIT;
            req_pc_s   = fetch_pc_r;
            fetch_pc_s = fetch_pc_r + 32'd4;
          end else begin
            state_s = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            state_s = ST_REQ;
            drop_s  = 1'b0;
          end else begin
            state_s = ST_WAIT;
          end
        end
        default: begin
          state_s = ST_REQ;
        end
      endcase
    end
  end

  // Queue pointer/count next state; a redirect empties the queue outright.
  always_comb begin
    q_count_s  = q_count_r;
    q_rd_ptr_s = q_rd_ptr_r;
    q_wr_ptr_s = q_wr_ptr_r;
    if (redirect_valid) begin
      q_count_s  = 2'd0;
      q_rd_ptr_s = 1'b0;
      q_wr_ptr_s = 1'b0;
    end else begin
      q_count_s = q_count_r + {1'b0, push_s} - {1'b0, pop_s};
      if (push_s) begin
        q_wr_ptr_s = ~q_wr_ptr_r;
      end else begin
        q_wr_ptr_s = q_wr_ptr_r;
      end
      if (pop_s) begin
        q_rd_ptr_s = ~q_rd_ptr_r;
      end else begin
        q_rd_ptr_s = q_rd_ptr_r;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_REQ;
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= 32'd0;
      drop_r     <= 1'b0;
      q_count_r  <= 2'd0;
      q_rd_ptr_r <= 1'b0;
      q_wr_ptr_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      req_pc_r   <= req_pc_s;
      drop_r     <= drop_s;
      q_count_r  <= q_count_s;
      q_rd_ptr_r <= q_rd_ptr_s;
      q_wr_ptr_r <= q_wr_ptr_s;
    end
  end

  // Queue storage: write the returned instruction with its request PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_pc_r[0]   <= 32'd0;
      q_pc_r[1]   <= 32'd0;
      q_inst_r[0] <= 32'd0;
      q_inst_r[1] <= 32'd0;
    end else if (push_s) begin
      q_pc_r[q_wr_ptr_r]   <= req_pc_r;
      q_inst_r[q_wr_ptr_r] <= imem_rsp_data;
    end else begin
      q_pc_r[q_wr_ptr_r]   <= q_pc_r[q_wr_ptr_r];
      q_inst_r[q_wr_ptr_r] <= q_inst_r[q_wr_ptr_r];
    end
  end

endmodule
